// File: rtl/bcd2bin_pkg.sv
// ============================================================================
// Module : bcd2bin_pkg
// Brief  : Shared constants, state encoding and digit check for the
//          BCD-to-binary sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd2bin_pkg;

  localparam int NDIG = 5;
  localparam int NBIN = 16;
  localparam int BCDW = 20;
  localparam int CNTW = 5;

  localparam logic [CNTW-1:0] CNT_LAST = 5'(NBIN);
  localparam logic [3:0]      CORR_SUB = 4'd3;
  localparam logic [3:0]      CORR_TH  = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_CORR  = 3'd3,
    S_FIN   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  function automatic logic has_bad_digit(input logic [BCDW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd2bin_seq_if.sv
// ============================================================================
// Module : bcd2bin_seq_if
// Brief  : Handshake and shift-register control bundle of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd2bin_seq_if;
  import bcd2bin_pkg::*;

  logic            start;
  logic [BCDW-1:0] bcd_in;
  logic [BCDW-1:0] bcd_hi;
  logic            rst_ld;
  logic [BCDW-1:0] in_R1;
  logic            shift;
  logic [NDIG-1:0] lda2;
  logic [BCDW-1:0] in_R2;
  logic            busy;
  logic            done;
  logic            ovf;
  logic            err;

  modport slave (
    input  start, bcd_in, bcd_hi,
    output rst_ld, in_R1, shift, lda2, in_R2, busy, done, ovf, err
  );

  modport master (
    output start, bcd_in, bcd_hi,
    input  rst_ld, in_R1, shift, lda2, in_R2, busy, done, ovf, err
  );

endinterface

`default_nettype wire

// File: rtl/bcd_digit_corr.sv
// ============================================================================
// Module : bcd_digit_corr
// Brief  : Reverse double-dabble correction of one BCD digit (>=8 -> -3).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_corr
  import bcd2bin_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit,
  output logic       o_needs_corr
);

  assign o_needs_corr = (i_digit >= CORR_TH);
  assign o_digit      = o_needs_corr ? (i_digit - CORR_SUB) : i_digit;

endmodule

`default_nettype wire

// File: rtl/bcd2bin_seq.sv
// ============================================================================
// Module : bcd2bin_seq
// Brief  : Sequencer and digit-correction stage driving the BCD-to-binary
//          right-shift register (reverse double-dabble, 16 iterations).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd2bin_seq
  import bcd2bin_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  bcd2bin_seq_if.slave bus
);

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [BCDW-1:0] in_r1_q, in_r1_d;
  logic            rst_ld_q, rst_ld_d;
  logic            shift_q, shift_d;
  logic [NDIG-1:0] lda2_q, lda2_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;

  logic [NDIG-1:0] needs_corr;
  logic [BCDW-1:0] corr_digits;

  generate
    for (genvar k = 0; k < NDIG; k++) begin : g_digit
      bcd_digit_corr u_corr (
        .i_digit      (bus.bcd_hi[4*k +: 4]),
        .o_digit      (corr_digits[4*k +: 4]),
        .o_needs_corr (needs_corr[k])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_r1_d = in_r1_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          in_r1_d = bus.bcd_in;
          ovf_d   = 1'b0;
          err_d   = has_bad_digit(bus.bcd_in);
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_d == CNT_LAST) ? S_FIN : S_CORR;
      end
      S_CORR:  state_d = S_SHIFT;
      S_FIN: begin
        // Whatever remains in the BCD field after the last shift is >= 65536.
        ovf_d   = |bus.bcd_hi;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register with it;
    // the correction mask samples bcd_hi after the preceding negedge shift.
    rst_ld_d = (state_d == S_LOAD);
    shift_d  = (state_d == S_SHIFT);
    lda2_d   = (state_d == S_CORR) ? needs_corr : '0;
    busy_d   = (state_d == S_LOAD) || (state_d == S_SHIFT) ||
               (state_d == S_CORR) || (state_d == S_FIN);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      in_r1_q  <= '0;
      rst_ld_q <= 1'b0;
      shift_q  <= 1'b0;
      lda2_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_r1_q  <= in_r1_d;
      rst_ld_q <= rst_ld_d;
      shift_q  <= shift_d;
      lda2_q   <= lda2_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign bus.rst_ld = rst_ld_q;
  assign bus.in_R1  = in_r1_q;
  assign bus.shift  = shift_q;
  assign bus.lda2   = lda2_q;
  assign bus.in_R2  = corr_digits;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ovf    = ovf_q;
  assign bus.err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
// ============================================================================
// Module : tb_bcd2bin_seq
// Brief  : Self-checking bench for bcd2bin_seq with a negedge shift-register
//          model and a decimal-arithmetic reference.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd2bin_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [35:0] sr = '0;

  bcd2bin_seq_if bus ();

  bcd2bin_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shift register the sequencer drives: BCD field [35:16], binary [15:0].
  always @(negedge clk) begin
    if (bus.rst_ld) sr <= {bus.in_R1, 16'h0000};
    else if (bus.shift) sr <= sr >> 1;
    else begin
      for (int k = 0; k < 5; k++)
        if (bus.lda2[k]) sr[16+4*k +: 4] <= bus.in_R2[4*k +: 4];
    end
  end
  assign bus.bcd_hi = sr[35:16];

  function automatic int ref_val(input logic [19:0] op);
    int v = 0;
    for (int k = 4; k >= 0; k--) v = v * 10 + int'(op[4*k +: 4]);
    return v;
  endfunction

  function automatic bit ref_bad(input logic [19:0] op);
    bit b = 1'b0;
    for (int k = 0; k < 5; k++) if (op[4*k +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {1'b0, bus.rst_ld, bus.shift, bus.lda2, bus.in_R1,
            bus.busy, bus.done, bus.ovf, bus.err};
  endfunction

  task automatic convert(input logic [19:0] op, input int rp_a, input int rp_b,
                         input bit chk_res);
    int done_cyc = -1, n_shift = 0, first_sh = -1, last_sh = -1;
    int n_busy = 0, n_ld = 0, n_overlap = 0, n_badlda = 0;
    int v;
    bit e_err;
    v     = ref_val(op);
    e_err = ref_bad(op);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = op;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.bcd_in = 20'($urandom);
    check("err_at_accept", 32'(bus.err), 32'(e_err));
    check("ovf_cleared", 32'(bus.ovf), 32'd0);
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      if (bus.shift) begin
        n_shift++;
        if (first_sh < 0) first_sh = cyc;
        last_sh = cyc;
      end
      if (bus.busy) n_busy++;
      if (bus.rst_ld) n_ld++;
      if (bus.shift && bus.lda2 != 5'd0) n_overlap++;
      if (bus.lda2 != 5'd0 && (cyc < 3 || cyc > 31 || cyc % 2 == 0)) n_badlda++;
      if (bus.done) done_cyc = cyc;
      bus.start = (cyc == rp_a || cyc == rp_b);
      if (done_cyc < 0) begin
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0;
    check("done_cycle", 32'(done_cyc), 32'd34);
    check("shift_count", 32'(n_shift), 32'd16);
    check("first_shift", 32'(first_sh), 32'd2);
    check("last_shift", 32'(last_sh), 32'd32);
    check("busy_cycles", 32'(n_busy), 32'd33);
    check("rst_ld_cycles", 32'(n_ld), 32'd1);
    check("shift_lda2_overlap", 32'(n_overlap), 32'd0);
    check("lda2_outside_corr", 32'(n_badlda), 32'd0);
    check("operand_latch", 32'(bus.in_R1), 32'(op));
    check("err_at_done", 32'(bus.err), 32'(e_err));
    if (chk_res) begin
      check("result", 32'(sr[15:0]), 32'(v % 65536));
      check("ovf", 32'(bus.ovf), 32'(v > 65535));
    end
    @(posedge clk); #1;
    check("done_pulse_end", 32'({bus.done, bus.busy}), 32'd0);
    check("err_sticky", 32'(bus.err), 32'(e_err));
  endtask

  initial begin
    logic [19:0] op;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    #2;
    check("reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", all_outs(), 32'd0);

    convert(20'h12345, -1, -1, 1'b1);
    convert(20'h65535, -1, -1, 1'b1);
    convert(20'h65536, -1, -1, 1'b1);
    convert(20'h99999, -1, -1, 1'b1);
    convert(20'h0000A, -1, -1, 1'b0);
    convert(20'h00000, -1, -1, 1'b1);
    convert(20'h00255, 5, 20, 1'b1);

    for (int i = 0; i < 8; i++) begin
      op = '0;
      for (int k = 0; k < 5; k++) op[4*k +: 4] = 4'($urandom_range(0, 9));
      convert(op, -1, -1, 1'b1);
    end

    // Abort a conversion with an asynchronous reset between clock edges.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 20'h12345;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 32'd0);
    @(posedge clk); #1;
    check("reset_held_outputs", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    convert(20'h00042, -1, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
